l1_port_arbiter: RTL
====================

Name: l1_port_arbiter

Overview:
- Shares the single request port of the L1 cache controller between two requesters: instruction fetch (requester 0) and load/store unit (requester 1).
- Round-robin arbitration; one transaction outstanding at a time.
- Latches the winner's request and drives the cache-side handshake.
- Returns the response to the winner, with a watchdog timeout that aborts hung transactions.

Parameters:
- ADDR_WIDTH, 32, address width of requester and cache ports.
- DATA_WIDTH, 32, write/read data width.
- TIMEOUT, 255, max cycles from issue to c_done before abort; must be >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- r0_req / r1_req  input  1  request valid; held until rN_gnt sampled high.
- r0_addr / r1_addr  input  ADDR_WIDTH  request address.
- r0_wdata / r1_wdata  input  DATA_WIDTH  write data.
- r0_we / r1_we  input  1  1=write, 0=read.
- r0_gnt / r1_gnt  output  1  one-cycle pulse: request accepted and latched.
- r0_done / r1_done  output  1  one-cycle pulse: transaction complete, rsp_data valid.
- r0_err / r1_err  output  1  one-cycle pulse with done on timeout.
- rsp_data  output  DATA_WIDTH  shared read-data return, valid with rN_done.
- c_valid  output  1  request to cache controller.
- c_addr  output  ADDR_WIDTH  latched address.
- c_wdata  output  DATA_WIDTH  latched write data.
- c_we  output  1  latched write enable.
- c_stall  input  1  cache busy; request accepted at an edge where c_valid=1 and c_stall=0.
- c_done  input  1  one-cycle completion pulse from cache.
- c_rdata  input  DATA_WIDTH  read data, valid with c_done.
- c_abort  output  1  one-cycle pulse: arbiter abandoned the transaction.

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-transaction):
  - state=IDLE; every output 0; rsp_data=0; timeout counter=0; last_grant=1, so requester 0 wins the first conflict.
  - An in-flight cache transaction is dropped silently; no done/err is issued.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Samples r0_req/r1_req at the edge.
  - One request: that requester wins. Both: the requester not equal to last_grant wins.
  - On a win, the next cycle has: winner's addr/wdata/we latched into c_*; rN_gnt=1 for exactly that cycle; c_valid=1; state=ISSUE; counter=0.
  - A req withdrawn before being sampled is ignored.
- ISSUE:
  - c_valid held high; c_* stable.
  - Edge with c_stall=0 → WAIT, c_valid=0 next cycle.
  - Counter increments every cycle in ISSUE and WAIT.
- WAIT:
  - Edge with c_done=1 → next cycle: rsp_data=c_rdata, winner's done=1, last_grant=winner, state=IDLE.
  - rsp_data updates for writes too; requesters ignore it for writes.
- Timeout:
  - If the counter reaches TIMEOUT in ISSUE or WAIT without c_done, next cycle: winner's done=1 and err=1, rsp_data=0, c_abort=1, c_valid=0, last_grant=winner, state=IDLE.
  - c_done on the same edge as expiry: done wins, no error.
- Ignored inputs: c_done while in IDLE or ISSUE is ignored.
- Throughput:
  - Minimum transaction is 3 cycles from gnt to done (gnt/ISSUE, WAIT, done).
  - A new gnt can follow a done cycle at the earliest 1 cycle later, since IDLE samples in the done cycle.
  - Requests held continuously by both sides alternate 0,1,0,1.
- Signal rules: gnt, done, err, c_abort are never high for both requesters simultaneously; gnt and done for one requester are never high in the same cycle.

Optional Feature:
- Macro: L1_ARB_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_gnt0, 32-bit: count of r0 grants.
  - perf_gnt1, 32-bit: count of r1 grants.
  - perf_conflict, 32-bit: cycles in IDLE with both req sampled high.
- All three reset to 0, saturate at all-ones, and have no effect on arbitration timing.
- When undefined, these ports and their logic are absent.

Test Plan:
- Single read: r0 read addr 32'h10000000; cache c_stall=0, c_done 2 cycles later with c_rdata=32'hdeadbeef → r0_gnt one pulse, c_addr=32'h10000000, c_we=0, r0_done with rsp_data=32'hdeadbeef, r1 outputs stay 0.
- Conflict: r0 and r1 request on the same edge after reset, both held → grant order r0, r1, r0; each gnt exactly one cycle; c_* always match the granted requester.
- Stall: r1 write 32'hcafef00d to 32'h20000000; c_stall=1 for 5 cycles → c_valid held 5+1 cycles with c_wdata=32'hcafef00d and c_we=1 unchanged; then WAIT; r1_done after c_done.
- Timeout: TIMEOUT=8, c_done never asserted → 8 cycles after gnt: r0_done=r0_err=c_abort=1 for one cycle, rsp_data=0; next r1 request is granted normally.
- Boundary: c_done on the same edge the counter hits TIMEOUT → done without err, no c_abort. Reset asserted during WAIT → all outputs 0 next cycle; a late c_done is ignored; the next conflict grants r0.
- With L1_ARB_PERF_CNT_EN: 3 conflicting rounds → perf_gnt0=2, perf_gnt1=1 after the third grant; perf_conflict equals the IDLE cycles counted with both reqs high.

Source files
------------

// File: rtl/l1_port_arbiter.sv
// Round-robin arbiter sharing the L1 cache request port between fetch (r0) and LSU (r1),
// with a watchdog that aborts hung transactions. Optional perf counters: L1_ARB_PERF_CNT_EN.
module l1_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic                  r0_we,
  input  logic                  r1_req,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic                  r1_we,
  output logic                  r0_gnt,
  output logic                  r1_gnt,
  output logic                  r0_done,
  output logic                  r1_done,
  output logic                  r0_err,
  output logic                  r1_err,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  c_valid,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_we,
  input  logic                  c_stall,
  input  logic                  c_done,
  input  logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  c_abort
`ifdef L1_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_gnt0,
  output logic [31:0]           perf_gnt1,
  output logic [31:0]           perf_conflict
`endif
);

  // state | meaning
  // IDLE  | no transaction; requests sampled each edge
  // ISSUE | c_valid high, waiting for the cache to take the request
  // WAIT  | request accepted by the cache, waiting for c_done
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic                  abort_d;
  logic [DATA_WIDTH-1:0] rsp_d;
  logic [ADDR_WIDTH-1:0] caddr_d;
  logic [DATA_WIDTH-1:0] cwdata_d;
  logic                  cwe_d;
  logic                  win;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      c_abort  <= 1'b0;
      rsp_data <= '0;
      c_addr   <= '0;
      c_wdata  <= '0;
      c_we     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      c_abort  <= abort_d;
      rsp_data <= rsp_d;
      c_addr   <= caddr_d;
      c_wdata  <= cwdata_d;
      c_we     <= cwe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = '0;
    abort_d  = 1'b0;
    rsp_d    = rsp_data;
    caddr_d  = c_addr;
    cwdata_d = c_wdata;
    cwe_d    = c_we;
    win      = 1'b0;

    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          // on a conflict the requester that did not win last time goes first
          win          = (r0_req && r1_req) ? ~last_q : r1_req;
          owner_d      = win;
          gnt_d[win]   = 1'b1;
          caddr_d      = win ? r1_addr  : r0_addr;
          cwdata_d     = win ? r1_wdata : r0_wdata;
          cwe_d        = win ? r1_we    : r0_we;
          cnt_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_LAST) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          abort_d         = 1'b1;
          rsp_d           = '0;
          last_d          = owner_q;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!c_stall) state_d = WAIT;
        end
      end
      WAIT: begin
        // a completion on the expiry edge still counts as a normal finish
        if (c_done) begin
          done_d[owner_q] = 1'b1;
          rsp_d           = c_rdata;
          last_d          = owner_q;
          state_d         = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          abort_d         = 1'b1;
          rsp_d           = '0;
          last_d          = owner_q;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign c_valid = (state_q == ISSUE);
  assign r0_gnt  = gnt_q[0];
  assign r1_gnt  = gnt_q[1];
  assign r0_done = done_q[0];
  assign r1_done = done_q[1];
  assign r0_err  = err_q[0];
  assign r1_err  = err_q[1];

`ifdef L1_ARB_PERF_CNT_EN
  // saturating event counters, observation only
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_gnt0     <= '0;
      perf_gnt1     <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt_d[0] && perf_gnt0 != '1) perf_gnt0 <= perf_gnt0 + 1'b1;
      if (gnt_d[1] && perf_gnt1 != '1) perf_gnt1 <= perf_gnt1 + 1'b1;
      if (state_q == IDLE && r0_req && r1_req && perf_conflict != '1)
        perf_conflict <= perf_conflict + 1'b1;
    end
  end
`endif

endmodule
